fft_frame_sequencer: RTL
========================

FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 SHALL have parameters (name, default, meaning): N_POINTS, 16, samples per frame.
REQ-002 SAMPLE_W, 16, sample width.
REQ-003 BIN_W, 32, FFT bin width.
REQ-004 SETTLE_CYCLES, 2, cycles the FFT datapath output is allowed to settle (range 1..15).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 smp_valid  in  1  audio sample present.
REQ-008 smp_data  in  SAMPLE_W  audio sample.
REQ-009 smp_ready  out  1  sequencer accepts a sample this cycle.
REQ-010 fft_t  out  N_POINTS*SAMPLE_W  frame to FFT datapath; sample j at bits [j*SAMPLE_W +: SAMPLE_W].
REQ-011 fft_f  in  N_POINTS*BIN_W  combinational FFT result; bin j at [j*BIN_W +: BIN_W].
REQ-012 res_valid  out  1  captured spectrum available.
REQ-013 res_ready  in  1  display side consumes spectrum.
REQ-014 res_bins  out  N_POINTS*BIN_W  captured spectrum.
REQ-015 res_frame_id  out  8  frame number of res_bins.
REQ-016 drop_cnt  out  8  samples lost while smp_ready low.

Function
REQ-017 SHALL implement FSM states FILL, SETTLE, CAPTURE.
REQ-018 FILL: smp_ready=1; on smp_valid, store smp_data at index fill_idx, increment fill_idx; on accepting index N_POINTS-1, go to SETTLE, clear fill_idx and settle counter.
REQ-019 SETTLE: smp_ready=0; fft_t held constant; after exactly SETTLE_CYCLES cycles, go to CAPTURE.
REQ-020 CAPTURE: smp_ready=0; if !res_valid or res_ready, latch fft_f into res_bins, set res_valid=1, increment frame counter, go to FILL; else stay in CAPTURE (stall).
REQ-021 Latency: last sample accepted in cycle k -> res_valid high from cycle k+SETTLE_CYCLES+2 when the output is free.
REQ-022 res_valid SHALL clear on res_valid&&res_ready unless a capture occurs the same cycle, in which case it stays 1 with new bins and id.
REQ-023 res_bins/res_frame_id SHALL be stable while res_valid=1 and res_ready=0.
REQ-024 res_frame_id SHALL be the frame counter value at capture; counter is 8-bit, wraps 255->0, first frame after reset is 0.
REQ-025 drop_cnt SHALL increment when smp_valid=1 and smp_ready=0; saturates at 255; never wraps.
REQ-026 fft_t SHALL be driven directly from the frame buffer registers (no combinational path from smp_data).
REQ-027 Partial frames SHALL never be presented as captured; only full N_POINTS frames reach CAPTURE.

Reset
REQ-028 rst SHALL asynchronously force: state FILL, fill_idx 0, settle counter 0, frame counter 0, res_valid 0, res_bins 0, drop_cnt 0, frame buffer 0 (fft_t=0).
REQ-029 rst asserted mid-frame or mid-stall SHALL discard the partial frame and pending result; smp_ready=1 in the first cycle after deassertion.

Structure
REQ-030 Shared package fft_pkg SHALL hold N_POINTS, SAMPLE_W, BIN_W defaults and the FSM state enum.
REQ-031 Frame buffer SHALL be one sub-module fft_sample_buffer (indexed write, clear on reset, flat parallel read-out).
REQ-032 FFT datapath is external; the sequencer instantiates no arithmetic.

Verification
REQ-033 Reset then feed samples 1..16 back-to-back, res_ready=1, FFT model identity (bin j = sample j) -> res_valid at cycle k+4 after 16th accept, res_bins bin j = j+1, res_frame_id 0.
REQ-034 Hold res_ready=0 across two full frames -> second frame stalls in CAPTURE, first result unchanged, smp_ready=0, drop_cnt counts every offered sample.
REQ-035 res_ready pulse in the CAPTURE cycle with res_valid=1 -> res_valid stays 1, bins/id update to the new frame (id 1).
REQ-036 Assert rst after 9 accepted samples, then send 16 samples -> first result contains only post-reset samples, id 0.
REQ-037 Stream 257 frames with res_ready=1 -> ids 0..255 then 0; drop_cnt saturates at 255 under continuous smp_valid.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared defaults and state encoding for the FFT frame sequencer.
package fft_pkg;

  localparam int N_POINTS_DEF = 16;
  localparam int SAMPLE_W_DEF = 16;
  localparam int BIN_W_DEF    = 32;

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/fft_sample_buffer.sv
// Frame buffer: one indexed sample write per cycle, flat parallel read-out.
module fft_sample_buffer
  import fft_pkg::*;
#(
  parameter int N_POINTS = N_POINTS_DEF,
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int IDX_W    = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_wr_en,
  input  logic [IDX_W-1:0]             i_wr_idx,
  input  logic [SAMPLE_W-1:0]          i_wr_data,
  output logic [N_POINTS*SAMPLE_W-1:0] o_frame
);

  logic [N_POINTS*SAMPLE_W-1:0] r_frame;

  // Store the accepted sample in its slot; the whole frame clears on reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_frame <= '0;
    end else if (i_wr_en) begin
      r_frame[i_wr_idx*SAMPLE_W +: SAMPLE_W] <= i_wr_data;
    end
  end

  assign o_frame = r_frame;

endmodule

// File: rtl/fft_frame_sequencer.sv
// Collects N_POINTS samples, lets the external FFT settle, captures the
// spectrum into a valid/ready output register.
//
//   state      | meaning
//   ST_FILL    | accepting samples into the frame buffer
//   ST_SETTLE  | frame complete, waiting SETTLE_CYCLES for the FFT output
//   ST_CAPTURE | latch spectrum once the output register is free (may stall)
module fft_frame_sequencer
  import fft_pkg::*;
#(
  parameter int N_POINTS      = N_POINTS_DEF,
  parameter int SAMPLE_W      = SAMPLE_W_DEF,
  parameter int BIN_W         = BIN_W_DEF,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_smp_valid,
  input  logic [SAMPLE_W-1:0]          i_smp_data,
  output logic                         o_smp_ready,
  output logic [N_POINTS*SAMPLE_W-1:0] o_fft_t,
  input  logic [N_POINTS*BIN_W-1:0]    i_fft_f,
  output logic                         o_res_valid,
  input  logic                         i_res_ready,
  output logic [N_POINTS*BIN_W-1:0]    o_res_bins,
  output logic [7:0]                   o_res_frame_id,
  output logic [7:0]                   o_drop_cnt
);

  localparam int               IDX_W       = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_POINTS - 1);
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  seq_state_t                 r_state;
  seq_state_t                 w_state_nxt;
  logic [IDX_W-1:0]           r_fill_idx;
  logic [3:0]                 r_settle_cnt;
  logic [7:0]                 r_frame_cnt;
  logic                       r_res_valid;
  logic [N_POINTS*BIN_W-1:0]  r_res_bins;
  logic [7:0]                 r_res_frame_id;
  logic [7:0]                 r_drop_cnt;
  logic                       w_smp_ready;
  logic                       w_accept;
  logic                       w_last;
  logic                       w_capture;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_FILL;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode plus ready/capture strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_smp_ready = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_FILL: begin
        w_smp_ready = 1'b1;
        if (i_smp_valid && (r_fill_idx == LAST_IDX)) w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (r_settle_cnt == SETTLE_LAST) w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (!r_res_valid || i_res_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_FILL;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  assign w_accept = w_smp_ready & i_smp_valid;
  assign w_last   = w_accept & (r_fill_idx == LAST_IDX);

  // Fill index and settle timer; both restart when a frame completes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fill_idx   <= '0;
      r_settle_cnt <= '0;
    end else begin
      if (w_last)        r_fill_idx <= '0;
      else if (w_accept) r_fill_idx <= r_fill_idx + 1'b1;
      if (w_last)                    r_settle_cnt <= '0;
      else if (r_state == ST_SETTLE) r_settle_cnt <= r_settle_cnt + 4'd1;
    end
  end

  // Result register: a capture wins over a same-cycle consume.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_res_valid    <= 1'b0;
      r_res_bins     <= '0;
      r_res_frame_id <= '0;
      r_frame_cnt    <= '0;
    end else if (w_capture) begin
      r_res_valid    <= 1'b1;
      r_res_bins     <= i_fft_f;
      r_res_frame_id <= r_frame_cnt;
      r_frame_cnt    <= r_frame_cnt + 8'd1;
    end else if (r_res_valid && i_res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  // Saturating count of samples offered while not ready.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_drop_cnt <= '0;
    end else if (i_smp_valid && !w_smp_ready && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  fft_sample_buffer #(
    .N_POINTS (N_POINTS),
    .SAMPLE_W (SAMPLE_W),
    .IDX_W    (IDX_W)
  ) u_buf (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (w_accept),
    .i_wr_idx  (r_fill_idx),
    .i_wr_data (i_smp_data),
    .o_frame   (o_fft_t)
  );

  assign o_smp_ready    = w_smp_ready;
  assign o_res_valid    = r_res_valid;
  assign o_res_bins     = r_res_bins;
  assign o_res_frame_id = r_res_frame_id;
  assign o_drop_cnt     = r_drop_cnt;

endmodule
